// File: rtl/int_divider_pkg.sv
// Shared helpers for the radix-2 signed integer divider.
package int_divider_pkg;

    // Bits needed to hold a step count running from w down to 0.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/int_divider_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
module int_divider_step
    import int_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, dvs};
        rem_n   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_n   = {quo[WIDTH-2:0], ~trial[WIDTH]};
    end

endmodule

// File: rtl/int_divider.sv
// Sequential radix-2 signed divider serving idiv/irem; one step per clock.
module int_divider
    import int_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             z,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r
);

    localparam int CW = cnt_w(WIDTH);

    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;

    state_t           state, state_n;
    logic             sign_q, sign_q_n;
    logic             sign_r, sign_r_n;
    logic [WIDTH-1:0] dvs, dvs_n;
    logic [WIDTH-1:0] rem, rem_n;
    logic [WIDTH-1:0] quo, quo_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             busy_n, z_n;
    logic [WIDTH-1:0] q_n, r_n;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] abs_x, abs_y;

    int_divider_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dvs   (dvs),
        .rem_n (step_rem),
        .quo_n (step_quo)
    );

    // Two's-complement negation also maps -2^(W-1) onto its unsigned magnitude.
    assign abs_x = x[WIDTH-1] ? -x : x;
    assign abs_y = y[WIDTH-1] ? -y : y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            z      <= 1'b0;
            q      <= '0;
            r      <= '0;
        end else begin
            state  <= state_n;
            sign_q <= sign_q_n;
            sign_r <= sign_r_n;
            dvs    <= dvs_n;
            rem    <= rem_n;
            quo    <= quo_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            z      <= z_n;
            q      <= q_n;
            r      <= r_n;
        end
    end

    always_comb begin
        state_n  = state;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        dvs_n    = dvs;
        rem_n    = rem;
        quo_n    = quo;
        cnt_n    = cnt;
        busy_n   = busy;
        z_n      = z;
        q_n      = q;
        r_n      = r;
        unique case (state)
            LOAD: begin
                sign_q_n = x[WIDTH-1] ^ y[WIDTH-1];
                sign_r_n = x[WIDTH-1];
                dvs_n    = abs_y;
                quo_n    = abs_x;
                rem_n    = '0;
                cnt_n    = CW'(WIDTH);
                if (y == '0) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    z_n     = 1'b1;
                    q_n     = '1;
                    r_n     = x;
                end else begin
                    state_n = RUN;
                end
            end
            RUN: begin
                rem_n = step_rem;
                quo_n = step_quo;
                cnt_n = cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    state_n = DONE;
                    busy_n  = 1'b0;
                    z_n     = 1'b0;
                    q_n     = sign_q ? -step_quo : step_quo;
                    r_n     = sign_r ? -step_rem : step_rem;
                end
            end
            DONE: begin
            end
            default: state_n = LOAD;
        endcase
    end

endmodule

// File: tb/tb_int_divider.sv
// Self-checking bench for int_divider: directed cases plus randomized runs.
module tb_int_divider;

    logic        clk;
    logic        rst;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        z;
    logic [31:0] q;
    logic [31:0] r;

    int n_checks;
    int n_pass;

    int_divider #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .x    (x),
        .y    (y),
        .busy (busy),
        .z    (z),
        .q    (q),
        .r    (r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_q(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (sb == 0) return 32'hFFFF_FFFF;
        res = sa / sb;
        return res[31:0];
    endfunction

    function automatic logic [31:0] ref_r(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        if (sb == 0) return a;
        res = sa % sb;
        return res[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", name, got, exp);
        else
            n_pass++;
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int edges);
        x   = a;
        y   = b;
        rst = 1'b0;
        @(negedge clk);
        rst   = 1'b1;
        edges = 0;
        forever begin
            @(posedge clk);
            #1;
            edges++;
            if (!busy || edges >= 100) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        x   = 32'd5;
        y   = 32'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, z, q, r} !== {1'b1, 1'b0, 32'd0, 32'd0})
            $display("FAIL reset: busy=%b z=%b q=%h r=%h expected 1 0 0 0", busy, z, q, r);
        else
            n_pass++;
    endtask

    task automatic test_directed();
        logic [31:0] xs [6];
        logic [31:0] ys [6];
        logic [31:0] eq [6];
        logic [31:0] er [6];
        int          edges;
        xs = '{32'd100, -32'sd100, 32'd100, -32'sd100, 32'h8000_0000, 32'h8000_0000};
        ys = '{32'd7, 32'd7, -32'sd7, -32'sd7, 32'hFFFF_FFFF, 32'd1};
        eq = '{32'd14, -32'sd14, -32'sd14, 32'd14, 32'h8000_0000, 32'h8000_0000};
        er = '{32'd2, -32'sd2, 32'd2, -32'sd2, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            run_div(xs[i], ys[i], edges);
            n_checks++;
            if (edges != 33 || busy !== 1'b0)
                $display("FAIL latency[%0d]: edges=%0d busy=%b expected 33 0", i, edges, busy);
            else
                n_pass++;
            n_checks++;
            if ({z, q, r} !== {1'b0, eq[i], er[i]})
                $display("FAIL directed[%0d]: z=%b q=%h r=%h expected 0 %h %h",
                         i, z, q, r, eq[i], er[i]);
            else
                n_pass++;
        end
    endtask

    task automatic test_div_zero();
        int edges;
        run_div(32'd55, 32'd0, edges);
        n_checks++;
        if (edges != 1)
            $display("FAIL divzero_latency: edges=%0d expected 1", edges);
        else
            n_pass++;
        for (int i = 0; i < 10; i++) begin
            x = $urandom;
            y = $urandom;
            @(negedge clk);
            n_checks++;
            if ({busy, z, q, r} !== {1'b0, 1'b1, 32'hFFFF_FFFF, 32'd55})
                $display("FAIL divzero_hold[%0d]: busy=%b z=%b q=%h r=%h expected 0 1 ffffffff 00000037",
                         i, busy, z, q, r);
            else
                n_pass++;
        end
    endtask

    task automatic test_abort();
        int edges;
        x   = 32'd1000;
        y   = 32'd3;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, q, r} !== {1'b1, 32'd0, 32'd0})
            $display("FAIL abort: busy=%b q=%h r=%h expected 1 0 0", busy, q, r);
        else
            n_pass++;
        run_div(32'd9, 32'd3, edges);
        check("abort_restart_edges", edges, 32'd33);
        check("abort_restart_q", q, 32'd3);
        check("abort_restart_r", r, 32'd0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        int          edges;
        int          bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = b >> $urandom_range(31, 0);
            if (i % 5 == 2) b = -32'sd1 * $signed({28'd0, b[3:0]});
            if (b == 32'd0) b = 32'd1;
            run_div(a, b, edges);
            n_checks++;
            if (edges != 33 || {z, q, r} !== {1'b0, ref_q(a, b), ref_r(a, b)}) begin
                if (bad < 10)
                    $display("FAIL random[%0d]: x=%h y=%h edges=%0d z=%b q=%h r=%h expected 33 0 %h %h",
                             i, a, b, edges, z, q, r, ref_q(a, b), ref_r(a, b));
                bad++;
            end else begin
                n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        x        = '0;
        y        = '0;
        test_reset();
        test_directed();
        test_div_zero();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
